// File: rtl/jtframe_shram_pkg.sv
// Shared definitions for the jtframe_shram_arb shared-RAM arbiter.
// Holds the FSM state encoding, the port-select constants and the round-robin pick helper.
package jtframe_shram_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    LATCH  = 2'd2
  } state_e;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  // On a tie the port that was not granted last wins.
  // A single request wins whatever the pointer says.
  function automatic logic rr_pick(input logic a_pend, input logic b_pend, input logic last);
    if (a_pend && b_pend) begin
      return (last == PORT_B) ? PORT_A : PORT_B;
    end
    return b_pend ? PORT_B : PORT_A;
  endfunction

endpackage

// File: rtl/jtframe_shram_port.sv
// Per-requester side of jtframe_shram_arb: done flag, clock-enable gating and read-data register.
// The CPU stalls while it has a request that has not been serviced yet.
module jtframe_shram_port #(
  parameter int DW = 8
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          cen_i,
  input  logic          cs_i,
  input  logic          set_done_i,
  input  logic          load_i,
  input  logic [DW-1:0] q_i,
  output logic          cen_o,
  output logic          pend_o,
  output logic [DW-1:0] din_o
);

  logic          done_q;
  logic          done_d;
  logic [DW-1:0] din_q;
  logic [DW-1:0] din_d;

  assign cen_o  = rst & cen_i & (~cs_i | done_q);
  assign pend_o = cs_i & ~done_q;
  assign din_o  = din_q;

  // Done is released once the CPU has consumed its cycle or has dropped the request.
  always_comb begin
    done_d = done_q;
    if (set_done_i) begin
      done_d = 1'b1;
    end else if (done_q && (cen_o || !cs_i)) begin
      done_d = 1'b0;
    end
    din_d = load_i ? q_i : din_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      done_q <= 1'b0;
      din_q  <= '0;
    end else begin
      done_q <= done_d;
      din_q  <= din_d;
    end
  end

endmodule

// File: rtl/jtframe_shram_arb.sv
// Two-port arbiter serialising a main CPU (A) and an MCU (B) onto one synchronous RAM.
// Define JTFRAME_SHRAM_PRIO_EN for fixed priority (A wins ties); default is round-robin.
module jtframe_shram_arb
  import jtframe_shram_pkg::*;
#(
  parameter int AW = 11,
  parameter int DW = 8
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          a_cs,
  input  logic          a_wrn,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_dout,
  output logic [DW-1:0] a_din,
  output logic          a_cen,
  input  logic          b_cs,
  input  logic          b_wrn,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_dout,
  output logic [DW-1:0] b_din,
  output logic          b_cen,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_data,
  input  logic [DW-1:0] ram_q
);

  state_e        state_q;
  state_e        state_d;
  logic          gnt_q;
  logic          gnt_d;
  logic          rd_q;
  logic          rd_d;
  logic          ram_we_q;
  logic          ram_we_d;
  logic [AW-1:0] ram_addr_q;
  logic [AW-1:0] ram_addr_d;
  logic [DW-1:0] ram_data_q;
  logic [DW-1:0] ram_data_d;
  logic          a_pend;
  logic          b_pend;
  logic          pick;
  logic          latch_a;
  logic          latch_b;

`ifdef JTFRAME_SHRAM_PRIO_EN
  assign pick = a_pend ? PORT_A : PORT_B;
`else
  logic last_q;
  logic last_d;

  assign pick = rr_pick(a_pend, b_pend, last_q);
`endif

  assign latch_a = (state_q == LATCH) && (gnt_q == PORT_A);
  assign latch_b = (state_q == LATCH) && (gnt_q == PORT_B);

  // Address and data are captured on the granting clock, so later bus changes are ignored.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    rd_d       = rd_q;
    ram_we_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
`ifndef JTFRAME_SHRAM_PRIO_EN
    last_d     = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (a_pend || b_pend) begin
          state_d    = ACCESS;
          gnt_d      = pick;
`ifndef JTFRAME_SHRAM_PRIO_EN
          last_d     = pick;
`endif
          rd_d       = (pick == PORT_B) ? b_wrn : a_wrn;
          ram_we_d   = (pick == PORT_B) ? ~b_wrn : ~a_wrn;
          ram_addr_d = (pick == PORT_B) ? b_addr : a_addr;
          ram_data_d = (pick == PORT_B) ? b_dout : a_dout;
        end
      end
      ACCESS:  state_d = LATCH;
      LATCH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      gnt_q      <= PORT_A;
      rd_q       <= 1'b1;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
`ifndef JTFRAME_SHRAM_PRIO_EN
      last_q     <= PORT_B;
`endif
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      rd_q       <= rd_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
`ifndef JTFRAME_SHRAM_PRIO_EN
      last_q     <= last_d;
`endif
    end
  end

  // Gating with rst lets a reset in ACCESS abort the write before the RAM samples it.
  assign ram_we   = ram_we_q & rst;
  assign ram_addr = ram_addr_q;
  assign ram_data = ram_data_q;

  jtframe_shram_port #(.DW(DW)) u_port_a (
    .clk        (clk),
    .rst        (rst),
    .cen_i      (cen),
    .cs_i       (a_cs),
    .set_done_i (latch_a),
    .load_i     (latch_a & rd_q),
    .q_i        (ram_q),
    .cen_o      (a_cen),
    .pend_o     (a_pend),
    .din_o      (a_din)
  );

  jtframe_shram_port #(.DW(DW)) u_port_b (
    .clk        (clk),
    .rst        (rst),
    .cen_i      (cen),
    .cs_i       (b_cs),
    .set_done_i (latch_b),
    .load_i     (latch_b & rd_q),
    .q_i        (ram_q),
    .cen_o      (b_cen),
    .pend_o     (b_pend),
    .din_o      (b_din)
  );

endmodule

// File: tb/tb_jtframe_shram_arb.sv
// Self-checking bench for jtframe_shram_arb with a synchronous RAM model and write/read scoreboards.
// Build with JTFRAME_SHRAM_PRIO_EN defined to check the fixed-priority variant.
module tb_jtframe_shram_arb;

  localparam int AW = 11;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cen;
  logic          aCs, aWrn, bCs, bWrn;
  logic [AW-1:0] aAddr, bAddr;
  logic [DW-1:0] aDout, bDout;
  logic [DW-1:0] aDin, bDin;
  logic          aCen, bCen;
  logic [AW-1:0] ramAddr;
  logic          ramWe;
  logic [DW-1:0] ramData;
  logic [DW-1:0] ramQ;

  logic [DW-1:0]    mem [0:(1<<AW)-1];
  logic             preEn = 1'b0;
  logic [AW-1:0]    preAddr;
  logic [DW-1:0]    preData;
  logic [AW+DW-1:0] expWrQ[$];
  logic [AW+DW-1:0] logWrQ[$];
  logic [DW-1:0]    expAQ[$];
  logic [DW-1:0]    expBQ[$];
  logic             weLast = 1'b0;
  int               total = 0;
  int               bad = 0;
  int               latA, latB;

  jtframe_shram_arb #(.AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .cen      (cen),
    .a_cs     (aCs),
    .a_wrn    (aWrn),
    .a_addr   (aAddr),
    .a_dout   (aDout),
    .a_din    (aDin),
    .a_cen    (aCen),
    .b_cs     (bCs),
    .b_wrn    (bWrn),
    .b_addr   (bAddr),
    .b_dout   (bDout),
    .b_din    (bDin),
    .b_cen    (bCen),
    .ram_addr (ramAddr),
    .ram_we   (ramWe),
    .ram_data (ramData),
    .ram_q    (ramQ)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM; every write it performs is logged for the scoreboard.
  always @(posedge clk) begin
    if (preEn) begin
      mem[preAddr] <= preData;
    end else if (ramWe) begin
      mem[ramAddr] <= ramData;
      logWrQ.push_back({ramAddr, ramData});
    end
    ramQ <= mem[ramAddr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [AW+DW-1:0] got;
    if (ramWe) checkOutput("weWidth", {31'd0, weLast}, 32'd0);
    weLast = ramWe;
    while (logWrQ.size() > 0) begin
      got = logWrQ.pop_front();
      if (expWrQ.size() == 0) checkOutput("wrUnexpected", {13'd0, got}, 32'hFFFFFFFF);
      else checkOutput("wrAddrData", {13'd0, got}, {13'd0, expWrQ.pop_front()});
    end
  end

  task automatic applyStimulus(input logic port, input logic cs, input logic wrn,
                               input logic [AW-1:0] addr, input logic [DW-1:0] dout);
    if (port == 1'b0) begin
      aCs = cs; aWrn = wrn; aAddr = addr; aDout = dout;
    end else begin
      bCs = cs; bWrn = wrn; bAddr = addr; bDout = dout;
    end
  endtask

  // Counts negedges until each watched port's cen passes; the CPU then drops its request.
  task automatic waitPorts(input logic watchA, input logic watchB, output int la, output int lb);
    la = -1;
    lb = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (watchA && la < 0 && aCen) begin
        la = c;
        if (aWrn) checkOutput("aDin", {24'd0, aDin}, {24'd0, expAQ.pop_front()});
        aCs = 1'b0;
      end
      if (watchB && lb < 0 && bCen) begin
        lb = c;
        if (bWrn) checkOutput("bDin", {24'd0, bDin}, {24'd0, expBQ.pop_front()});
        bCs = 1'b0;
      end
      if ((!watchA || la >= 0) && (!watchB || lb >= 0)) break;
    end
    if (watchA && la < 0) checkOutput("aTimeout", 32'd0, 32'd1);
    if (watchB && lb < 0) checkOutput("bTimeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_aCen"}, {31'd0, aCen}, 32'd0);
    checkOutput({tag, "_bCen"}, {31'd0, bCen}, 32'd0);
    checkOutput({tag, "_ramWe"}, {31'd0, ramWe}, 32'd0);
    checkOutput({tag, "_ramAddr"}, {21'd0, ramAddr}, 32'd0);
    checkOutput({tag, "_ramData"}, {24'd0, ramData}, 32'd0);
    checkOutput({tag, "_aDin"}, {24'd0, aDin}, 32'd0);
    checkOutput({tag, "_bDin"}, {24'd0, bDin}, 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    cen = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, '0, '0);
    applyStimulus(1'b1, 1'b0, 1'b1, '0, '0);
    preAddr = 11'h010; preData = 8'h5A; preEn = 1'b1;
    @(negedge clk);
    preEn = 1'b0;
    repeat (2) @(negedge clk);
    checkResetValues("reset");
    rst = 1'b1;
    @(negedge clk);

    $display("[TB] single A read");
    applyStimulus(1'b0, 1'b1, 1'b1, 11'h010, 8'h00);
    expAQ.push_back(8'h5A);
    waitPorts(1'b1, 1'b0, latA, latB);
    checkOutput("aReadLat", latA, 32'd3);

    $display("[TB] single B write then read");
    applyStimulus(1'b1, 1'b1, 1'b0, 11'h7FF, 8'hC3);
    expWrQ.push_back({11'h7FF, 8'hC3});
    waitPorts(1'b0, 1'b1, latA, latB);
    checkOutput("bWriteLat", latB, 32'd3);
    applyStimulus(1'b1, 1'b1, 1'b1, 11'h7FF, 8'h00);
    expBQ.push_back(8'hC3);
    waitPorts(1'b0, 1'b1, latA, latB);
    checkOutput("bReadLat", latB, 32'd3);
    checkOutput("aDinStable", {24'd0, aDin}, 32'h5A);

    $display("[TB] ties after reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b1, 11'h010, 8'h00);
    applyStimulus(1'b1, 1'b1, 1'b1, 11'h7FF, 8'h00);
    expAQ.push_back(8'h5A);
    expBQ.push_back(8'hC3);
    waitPorts(1'b1, 1'b1, latA, latB);
    checkOutput("tie1A", latA, 32'd3);
    checkOutput("tie1B", latB, 32'd6);
    applyStimulus(1'b0, 1'b1, 1'b1, 11'h010, 8'h00);
    expAQ.push_back(8'h5A);
    waitPorts(1'b1, 1'b0, latA, latB);
    checkOutput("soloA", latA, 32'd3);
    applyStimulus(1'b0, 1'b1, 1'b1, 11'h7FF, 8'h00);
    applyStimulus(1'b1, 1'b1, 1'b1, 11'h010, 8'h00);
    expAQ.push_back(8'hC3);
    expBQ.push_back(8'h5A);
    waitPorts(1'b1, 1'b1, latA, latB);
`ifdef JTFRAME_SHRAM_PRIO_EN
    checkOutput("tie2A", latA, 32'd3);
    checkOutput("tie2B", latB, 32'd6);
`else
    checkOutput("tie2A", latA, 32'd6);
    checkOutput("tie2B", latB, 32'd3);
`endif
    applyStimulus(1'b1, 1'b1, 1'b1, 11'h7FF, 8'h00);
    expBQ.push_back(8'hC3);
    waitPorts(1'b0, 1'b1, latA, latB);
    checkOutput("soloB", latB, 32'd3);

    $display("[TB] same-address collision");
    applyStimulus(1'b0, 1'b1, 1'b0, 11'h100, 8'h11);
    applyStimulus(1'b1, 1'b1, 1'b0, 11'h100, 8'h22);
    expWrQ.push_back({11'h100, 8'h11});
    expWrQ.push_back({11'h100, 8'h22});
    waitPorts(1'b1, 1'b1, latA, latB);
    checkOutput("collA", latA, 32'd3);
    checkOutput("collB", latB, 32'd6);
    checkOutput("collMem", {24'd0, mem[11'h100]}, 32'h22);
    applyStimulus(1'b0, 1'b1, 1'b1, 11'h100, 8'h00);
    expAQ.push_back(8'h22);
    waitPorts(1'b1, 1'b0, latA, latB);
    checkOutput("collReadLat", latA, 32'd3);

    $display("[TB] withdrawal during ACCESS");
    applyStimulus(1'b0, 1'b1, 1'b0, 11'h020, 8'h5C);
    expWrQ.push_back({11'h020, 8'h5C});
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 11'h3FF, 8'hEE);
    repeat (5) @(negedge clk);
    checkOutput("wdDrained", expWrQ.size(), 32'd0);
    checkOutput("wdMem", {24'd0, mem[11'h020]}, 32'h5C);
    applyStimulus(1'b0, 1'b1, 1'b1, 11'h020, 8'h00);
    expAQ.push_back(8'h5C);
    waitPorts(1'b1, 1'b0, latA, latB);
    checkOutput("wdReadLat", latA, 32'd3);

    $display("[TB] reset during ACCESS");
    applyStimulus(1'b1, 1'b1, 1'b0, 11'h7FF, 8'h99);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rstWeGate", {31'd0, ramWe}, 32'd0);
    @(negedge clk);
    checkResetValues("midRst");
    bCs = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rstMem", {24'd0, mem[11'h7FF]}, 32'hC3);
    applyStimulus(1'b1, 1'b1, 1'b1, 11'h7FF, 8'h00);
    expBQ.push_back(8'hC3);
    waitPorts(1'b0, 1'b1, latA, latB);
    checkOutput("rstReadLat", latB, 32'd3);

    repeat (3) @(negedge clk);
    checkOutput("wrQEmpty", expWrQ.size(), 32'd0);
    checkOutput("rdQEmpty", expAQ.size() + expBQ.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jtframe_shram_arb.md
# jtframe_shram_arb

Two-requester arbiter for a single-port shared RAM between a main CPU (port A) and a 6801-family MCU (port B), as used in MCU-assisted arcade boards. Each requester sees a private bus; the arbiter serialises accesses onto one synchronous RAM and stalls the losing requester by gating its clock enable. It sits between the MCU wrapper's external-RAM decode and the game's main CPU bus.

## Interface
Parameters:
- AW, 11, RAM address width.
- DW, 8, data width.

Ports (`rst` is synchronous, active-low; clock is `clk`):
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low.
- cen  in  1  common CPU clock-enable pulse.
- a_cs  in  1  port A request, held until A's gated cen fires.
- a_wrn  in  1  port A write when 0, read when 1.
- a_addr  in  AW  port A address.
- a_dout  in  DW  port A write data.
- a_din  out  DW  port A read data (registered).
- a_cen  out  1  gated cen for the A CPU.
- b_cs, b_wrn, b_addr, b_dout, b_din, b_cen: same as the A ports, for port B.
- ram_addr  out  AW  RAM address.
- ram_we  out  1  RAM write strobe.
- ram_data  out  DW  RAM write data.
- ram_q  in  DW  RAM read data, valid one clk after address.

## Operation
- Each port has a done flag. x_cen = cen & (~x_cs | x_done). The requester stalls while it has a pending request.
- FSM states:
  - IDLE: if any pending request (x_cs & ~x_done), grant one and go to ACCESS.
  - ACCESS: drive ram_addr/ram_data from the granted port. ram_we = ~x_wrn for exactly this clk. Go to LATCH.
  - LATCH: x_din <= ram_q for a read; x_din unchanged for a write. Set x_done. Go to IDLE.
- Arbitration is round-robin. A last-granted pointer is updated on every grant. On a simultaneous request, the port not last granted wins. A single request is granted regardless of the pointer.
- x_done clears on the first clk where (x_cen & x_done), i.e. the CPU consumed the cycle, or where x_cs is low.
- Port-request inputs are sampled only in IDLE. Address and data changes during ACCESS are ignored; the captured values come from the granting clk.
- If a request is withdrawn (cs low) in ACCESS or LATCH, the access still completes. The done flag clears next clk and no stall results.
- Same-address writes from both ports are serialised, and the later grant wins.
- Reset: FSM to IDLE, a_din = b_din = 0, ram_we = 0, ram_addr = 0, ram_data = 0, done flags 0, pointer = B (so A wins the first tie). a_cen and b_cen are forced 0 while rst is low. Reset mid-access aborts with no write and no done.

## Timing
- Uncontended latency: request seen in IDLE at clk n → ACCESS at n+1 → LATCH at n+2 → done at n+3. The first un-gated cen is at or after n+3.
- Contended: the loser's grant occurs at the earliest n+3, and it is done at n+6.
- ram_we width: exactly one clk per write access, never in IDLE or LATCH.
- x_din stays stable from LATCH until that port's next read LATCH.
- The arbiter issues at most one access per 3 clk. The cen period must be ≥ 6 clk for both ports to finish in one cen period under contention.

## Configuration
- `JTFRAME_SHRAM_PRIO_EN` defined: fixed priority, port A always wins ties, and the pointer logic is removed.
- Macro undefined: round-robin as above.

## Structure
- Package jtframe_shram_pkg holds:
  - the FSM state enum (IDLE, ACCESS, LATCH);
  - a port-select constant (PORT_A = 0, PORT_B = 1).
- Sub-module jtframe_shram_port, instantiated twice, holds the per-port done flag, cen gating and din register. The top level holds the FSM, arbitration and RAM mux.

## Test plan
- Single A read: RAM[0x010] = 0x5A, A reads 0x010 → ram_we never high, a_din = 0x5A at n+3, a_cen gated for 3 clk then passes the next cen.
- Single B write: B writes 0xC3 to 0x7FF → one ram_we pulse with ram_addr = 0x7FF and ram_data = 0xC3, b_done set at n+3, then a B read returns 0xC3.
- Simultaneous A and B requests after reset → A granted first, B granted at n+3. On the next simultaneous pair, B is granted first. With `JTFRAME_SHRAM_PRIO_EN` defined, A is granted first both times.
- Same-address collision: A writes 0x11 and B writes 0x22 to 0x100 simultaneously → the final RAM value is 0x22 (round-robin). B's cen stays gated ≥ 6 clk.
- Withdrawal and reset: A cs is dropped during ACCESS → the write still occurs once and a_done clears the next clk. rst is driven low during ACCESS of a write → no ram_we pulse, all outputs return to their reset values.
